// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared sizes and word/address types for the 4K x 4 data RAM.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_tristate_buf.sv
`default_nettype none
// ============================================================================
// Module   : ram_tristate_buf
// Purpose  : WIDTH-bit tri-state driver; drives din onto bus while oe is high.
// Revision : 1.0 - initial release
// ============================================================================
module ram_tristate_buf
  import ram_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = oe ? din : {WIDTH{1'bz}};

endmodule : ram_tristate_buf
`default_nettype wire

// File: rtl/ram_4kx4_bidir.sv
`default_nettype none
// ============================================================================
// Module   : ram_4kx4_bidir
// Purpose  : 4096 x 4 single-port RAM on a shared bidirectional bus with
//            synchronous writes, combinational reads and per-word valid bits.
// Revision : 1.0 - initial release
// ============================================================================
module ram_4kx4_bidir
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  addr_t             address_RAM,
  input  logic              csRAM,
  input  logic              weRAM,
  inout  wire  [DATA_W-1:0] data
);

  word_t            mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             wr_en;
  logic             rd_en;
  word_t            rd_word;

  assign wr_en = csRAM & weRAM;
  assign rd_en = rst_n & csRAM & ~weRAM;

  // Valid bits give deterministic post-reset reads without clearing the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[address_RAM] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[address_RAM] <= data;
    end
  end

  assign rd_word = valid[address_RAM] ? mem[address_RAM] : '0;

  ram_tristate_buf #(
    .WIDTH (DATA_W)
  ) u_bus_drv (
    .oe  (rd_en),
    .din (rd_word),
    .bus (data)
  );

endmodule : ram_4kx4_bidir
`default_nettype wire

// File: tb/tb_ram_4kx4_bidir.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_4kx4_bidir
// Purpose  : Directed bench for ram_4kx4_bidir with an array-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_4kx4_bidir;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] addr = '0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic        drv_en = 1'b0;
  logic [3:0]  drv_val = '0;
  tri1  [3:0]  data;

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  // Reference state: what each word holds and whether it was written since reset.
  logic [3:0] ref_mem   [4096];
  bit         ref_valid [4096];

  // Released bus floats to the pull-up value.
  assign data = drv_en ? drv_val : 4'bzzzz;

  ram_4kx4_bidir dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .address_RAM (addr),
    .csRAM       (cs),
    .weRAM       (we),
    .data        (data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && cs && we) begin
      ref_mem[addr]   = drv_en ? drv_val : 4'b1111;
      ref_valid[addr] = 1'b1;
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 4096; i++) ref_valid[i] = 1'b0;
  end

  function automatic logic [3:0] expected_bus();
    if (rst_n && cs && !we)
      return ref_valid[addr] ? ref_mem[addr] : 4'b0000;
    return drv_en ? drv_val : 4'b1111;
  endfunction

  task automatic check(input string name, input logic [3:0] want);
    n_checks++;
    if (data === want) n_pass++;
    else $display("FAIL %s: addr=%h got=%b want=%b", name, addr, data, want);
  endtask

  always @(negedge clk) begin
    #3;
    if (!done) check("cycle", expected_bus());
  end

  task automatic step(input logic [11:0] a, input logic c, input logic w,
                      input logic de, input logic [3:0] dv);
    @(negedge clk);
    addr = a; cs = c; we = w; drv_en = de; drv_val = dv;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i]   = 4'b0000;
      ref_valid[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(12'h000, 1, 0, 0, 4'h0); check("post_reset_000", 4'b0000);
    step(12'h001, 1, 0, 0, 4'h0); check("post_reset_001", 4'b0000);
    step(12'h002, 1, 0, 0, 4'h0); check("post_reset_002", 4'b0000);

    step(12'h000, 1, 1, 1, 4'b1010);
    step(12'h001, 1, 1, 1, 4'b1011);
    step(12'h002, 1, 1, 1, 4'b1100);
    step(12'h000, 1, 0, 0, 4'h0); check("readback_000", 4'b1010);
    step(12'h001, 1, 0, 0, 4'h0); check("readback_001", 4'b1011);
    step(12'h002, 1, 0, 0, 4'h0); check("readback_002", 4'b1100);

    step(12'h000, 0, 0, 0, 4'h0); check("release_cs0", 4'b1111);
    step(12'h000, 1, 1, 0, 4'h0); check("release_write", 4'b1111);
    step(12'h001, 1, 0, 0, 4'h0); check("release_no_side", 4'b1011);

    step(12'h000, 0, 1, 1, 4'b1111);
    step(12'h000, 1, 0, 0, 4'h0); check("cs_gated_write", 4'b1111);
    step(12'h000, 1, 1, 1, 4'b1010);
    step(12'h000, 0, 1, 1, 4'b0001);
    step(12'h000, 1, 0, 0, 4'h0); check("cs_gating", 4'b1010);

    step(12'hFFF, 1, 1, 1, 4'b0101);
    step(12'hFFF, 1, 0, 0, 4'h0); check("top_readback", 4'b0101);
    rst_n = 1'b0;
    #1 check("reset_release", 4'b1111);
    step(12'hFFF, 1, 1, 1, 4'b0111);
    step(12'hFFF, 1, 0, 0, 4'h0); check("reset_hold_read", 4'b1111);
    rst_n = 1'b1;
    #1 check("after_reset_fff", 4'b0000);
    step(12'h001, 1, 0, 0, 4'h0); check("after_reset_001", 4'b0000);

    step(12'h000, 1, 1, 1, 4'b0011);
    step(12'h000, 1, 1, 1, 4'b0110);
    step(12'hFFF, 1, 1, 1, 4'b1001);
    step(12'h000, 1, 0, 0, 4'h0); check("overwrite_000", 4'b0110);
    step(12'hFFF, 1, 0, 0, 4'h0); check("extreme_fff", 4'b1001);
    step(12'h000, 1, 0, 0, 4'h0); check("extreme_000", 4'b0110);
    step(12'h123, 1, 0, 0, 4'h0); check("unwritten_123", 4'b0000);

    step(12'h000, 0, 0, 0, 4'h0);
    @(negedge clk); #4;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram_4kx4_bidir
`default_nettype wire
